// File: rtl/seqsum_frame.sv
// seqsum_frame
//   Adds operand pairs a+b and accumulates them over a frame of accepted beats.
//   A frame closes on in_last or when MAX_BEATS beats have been summed. One
//   result per frame is presented on a valid/ready output port and held stable
//   until the consumer takes it.
//
// Parameters
//   DW        operand width (a, b), unsigned
//   ACC_EXT   extra accumulator bits; AW = DW + ACC_EXT
//   MAX_BEATS beat cap per frame (>= 1); CW = $clog2(MAX_BEATS + 1)
//   SAT       0: accumulator wraps mod 2^AW, 1: clamps at 2^AW-1
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous reset, active-high
//   in_valid  operand beat valid
//   in_ready  block can accept a beat (low while holding a result or in reset)
//   a, b      operands (DW bits each)
//   in_last   final beat of the frame, qualified by in_valid & in_ready
//   y_valid   frame result valid
//   y_ready   consumer accepts the result
//   y         frame sum (AW bits)
//   y_beats   number of beats summed into y (CW bits)
//   y_ovf     accumulator wrapped or clamped during this frame
//   y_trunc   frame was closed by the MAX_BEATS cap rather than in_last

module seqsum_frame #(
  parameter int DW        = 32,
  parameter int ACC_EXT   = 8,
  parameter int MAX_BEATS = 256,
  parameter int SAT       = 0,
  localparam int AW       = DW + ACC_EXT,
  localparam int CW       = $clog2(MAX_BEATS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          in_last,
  output logic          y_valid,
  input  logic          y_ready,
  output logic [AW-1:0] y,
  output logic [CW-1:0] y_beats,
  output logic          y_ovf,
  output logic          y_trunc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          ovf;

  logic          beat;
  logic [AW+1:0] base;
  logic [AW+1:0] sum;
  logic          sum_ovf;
  logic [AW-1:0] acc_next;
  logic [CW-1:0] cnt_next;
  logic          ovf_next;
  logic          close;

  // Ready depends only on state and reset so the source never sees a
  // combinational path from its own valid back to ready.
  assign in_ready = ~rst & (state != HOLD);
  assign beat     = in_valid & in_ready;

  // Next accumulator value for an accepted beat. The first beat of a frame
  // starts from zero; the sum is formed two bits wider than the accumulator
  // so that acc + a + b can never lose a carry before overflow is judged.
  always_comb begin
    base     = (state == ACC) ? {2'b00, acc} : '0;
    sum      = base + {{(AW + 2 - DW){1'b0}}, a} + {{(AW + 2 - DW){1'b0}}, b};
    sum_ovf  = |sum[AW+1:AW];
    if (sum_ovf && (SAT != 0)) begin
      acc_next = '1;
    end else begin
      acc_next = sum[AW-1:0];
    end
    cnt_next = (state == ACC) ? cnt + CW'(1) : CW'(1);
    ovf_next = ((state == ACC) & ovf) | sum_ovf;
    close    = in_last | (cnt_next == CW'(MAX_BEATS));
  end

  // Frame FSM. The closing beat loads the result registers on the same edge
  // that enters HOLD, so y_valid rises right after the last beat is accepted.
  // The running accumulator is cleared at that point; the next frame always
  // starts from zero regardless of how the previous one ended.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      y_valid <= 1'b0;
      y       <= '0;
      y_beats <= '0;
      y_ovf   <= 1'b0;
      y_trunc <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (beat) begin
            if (close) begin
              state   <= HOLD;
              acc     <= '0;
              cnt     <= '0;
              ovf     <= 1'b0;
              y       <= acc_next;
              y_beats <= cnt_next;
              y_ovf   <= ovf_next;
              y_trunc <= ~in_last;
              y_valid <= 1'b1;
            end else begin
              state <= ACC;
              acc   <= acc_next;
              cnt   <= cnt_next;
              ovf   <= ovf_next;
            end
          end
        end
        HOLD: begin
          // y and its side-band flags keep their values after the handshake.
          if (y_ready) begin
            state   <= IDLE;
            y_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
